cpu_bus_if: RTL



---
 rtl/cpu_bus_if.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cpu_bus_if.sv
// cpu_bus_if: stage-side initiator for the scratch-pad memory and system bus.
// SPM accesses are combinational; bus accesses run a req/grant/ready FSM.
module cpu_bus_if #(
  parameter int         ADDR_W     = 30,
  parameter int         DATA_W     = 32,
  parameter int         SPM_ADDR_W = 12,
  parameter logic [2:0] SPM_SEL    = 3'b011
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic              as_n,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic              spm_as_n,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  output logic              bus_req_n,
  input  logic              bus_grnt_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_n,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_n
);

  localparam logic READ = 1'b1;

  typedef enum logic [2:0] {
    IDLE, SPM_RD, REQ, ACCESS, WAIT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rd_buf;
  logic              is_spm;
  logic              accept;
  logic              spm_acc;
  logic              bus_acc;

  assign is_spm  = addr[ADDR_W-1 -: 3] == SPM_SEL;
  assign accept  = reset_n && (state == IDLE) && !as_n && !flush;
  assign spm_acc = accept && is_spm;
  assign bus_acc = accept && !is_spm;

  assign spm_as_n    = !spm_acc;
  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  always_comb begin
    busy    = 1'b0;
    rd_data = rd_buf;
    unique case (state)
      IDLE:    busy = bus_acc || (spm_acc && rw == READ);
      SPM_RD:  rd_data = spm_rd_data;
      REQ:     busy = 1'b1;
      ACCESS: begin
        busy = bus_rdy_n;
        if (!bus_rdy_n) rd_data = bus_rd_data;
      end
      WAIT:    busy = 1'b0;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_buf      <= '0;
      bus_req_n   <= 1'b1;
      bus_as_n    <= 1'b1;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            spm_acc && rw == READ: state <= SPM_RD;
            bus_acc: begin
              bus_req_n   <= 1'b0;
              bus_addr    <= addr;
              bus_rw      <= rw;
              bus_wr_data <= wr_data;
              state       <= REQ;
            end
            default: state <= IDLE;
          endcase
        end
        SPM_RD: begin
          rd_buf <= spm_rd_data;
          state  <= stall ? WAIT : IDLE;
        end
        REQ: begin
          if (!bus_grnt_n) begin
            bus_as_n <= 1'b0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          bus_as_n <= 1'b1;
          if (!bus_rdy_n) begin
            bus_req_n <= 1'b1;
            if (bus_rw == READ) rd_buf <= bus_rd_data;
            state <= stall ? WAIT : IDLE;
          end
        end
        // hold off re-issue of a request the stalled stage still presents
        WAIT: if (!stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
